div: RTL and testbench

- Sequential 32-bit integer divider for the CPU's HI/LO unit; the counterpart of the shift/add multiplier.
- Computes quotient and remainder for DIV (signed) and DIVU (unsigned) using a restoring shift/subtract loop, one quotient bit per clock.
- Results follow the MIPS convention: remainder to hi, quotient to low.
- Sits beside the multiplier and is started by the control unit with a one-cycle start pulse.

---
 rtl/alu_pkg.sv | 15 +
 rtl/div_step.sv | 26 ++
 rtl/div.sv | 135 +++++++++++++
 tb/tb_div.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the HI/LO arithmetic unit.
// Holds the divider width default, iteration count and state encoding.
package alu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int ITER      = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract.
// Ports: rem/quo/divisor in, rem_next/quo_next out (purely combinational).
module div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;

    // One spare bit above the remainder so the trial sign is unambiguous.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {2'b00, divisor};
    assign fits     = ~trial[WIDTH+1];
    assign rem_next = fits ? trial[WIDTH:0] : shifted[WIDTH:0];
    assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/div.sv
// Sequential restoring divider (DIV/DIVU), one quotient bit per clock.
// Ports: clk, reset (sync, active-low), divInit/signed_op/value_A_Dd/
// value_B_Ds start request and operands; hi (remainder), low (quotient),
// busy, done (one-cycle pulse), div0 (divide-by-zero, with done).
module div
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             divInit,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] value_A_Dd,
    input  logic [WIDTH-1:0] value_B_Ds,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] low,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int ITERS = (WIDTH == DIV_WIDTH) ? ITER : WIDTH;
    localparam int CW    = $clog2(ITERS + 1);

    div_state_e state;
    div_state_e state_nx;

    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             last;

    // Negating 0x80000000 yields 0x80000000, which is correct as unsigned.
    assign abs_a = (signed_op && value_A_Dd[WIDTH-1]) ? -value_A_Dd
                                                      : value_A_Dd;
    assign abs_b = (signed_op && value_B_Ds[WIDTH-1]) ? -value_B_Ds
                                                      : value_B_Ds;
    assign last  = (cnt == CW'(ITERS - 1));
    assign busy  = (state != IDLE);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvs),
        .rem_next(rem_nx),
        .quo_next(quo_nx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (divInit) begin
                    state_nx = (value_B_Ds == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = FIX;
                end
            end
            FIX:     state_nx = IDLE;
            ZERO:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi     <= '0;
            low    <= '0;
            done   <= 1'b0;
            div0   <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (divInit) begin
                        sign_q <= signed_op &
                                  (value_A_Dd[WIDTH-1] ^ value_B_Ds[WIDTH-1]);
                        sign_r <= signed_op & value_A_Dd[WIDTH-1];
                        // Dividend enters the quotient register and is
                        // shifted out into the remainder bit by bit.
                        rem    <= '0;
                        quo    <= abs_a;
                        dvs    <= abs_b;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    low  <= sign_q ? -quo : quo;
                    hi   <= sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    done <= 1'b1;
                end
                ZERO: begin
                    done <= 1'b1;
                    div0 <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for the sequential divider.
// Stimulus pushes expected results; a monitor checks them on done.
module tb_div;

    logic        clk;
    logic        reset;
    logic        divInit;
    logic        signed_op;
    logic [31:0] value_A_Dd;
    logic [31:0] value_B_Ds;
    logic [31:0] hi;
    logic [31:0] low;
    logic        busy;
    logic        done;
    logic        div0;

    div dut (
        .clk       (clk),
        .reset     (reset),
        .divInit   (divInit),
        .signed_op (signed_op),
        .value_A_Dd(value_A_Dd),
        .value_B_Ds(value_B_Ds),
        .hi        (hi),
        .low       (low),
        .busy      (busy),
        .done      (done),
        .div0      (div0)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] last_hi = 0;
    logic [31:0] last_lo = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void check(string name, longint act, longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: plain 64-bit arithmetic; truncation toward zero and
    // dividend-signed remainder come from the language operators.
    task automatic model(input logic s, input logic [31:0] a,
                         input logic [31:0] b, output exp_t e);
        longint sa, sb_, q, r;
        if (s) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb_ = longint'({32'h0, b});
        end
        if (b == 0) begin
            e.hi = last_hi;
            e.lo = last_lo;
            e.dz = 1'b1;
        end else begin
            q = sa / sb_;
            r = sa % sb_;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy && done) check("busy_with_done", 1, 0);
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("hi", hi, e.hi);
                check("low", low, e.lo);
                check("div0", div0, e.dz);
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) begin
            check("idle_timeout", 1, 0);
        end
    endtask

    // Issued at posedge+1 with the DUT idle; the following edge is E0.
    task automatic start(input logic s, input logic [31:0] a,
                         input logic [31:0] b, input bit expect_it);
        exp_t e;
        divInit    = 1'b1;
        signed_op  = s;
        value_A_Dd = a;
        value_B_Ds = b;
        @(posedge clk);
        #1;
        divInit = 1'b0;
        if (expect_it) begin
            model(s, a, b, e);
            e.cyc = cyc + ((b == 0) ? 1 : 33);
            sb.push_back(e);
        end
    endtask

    task automatic op(input logic s, input logic [31:0] a,
                      input logic [31:0] b);
        wait_idle();
        start(s, a, b, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          nb;
        logic [31:0] ra, rb;
        logic [31:0] spec[6];
        divInit    = 1'b0;
        signed_op  = 1'b0;
        value_A_Dd = '0;
        value_B_Ds = '0;
        reset      = 1'b0;
        cycles(3);
        check("rst_hi", hi, 0);
        check("rst_low", low, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        reset = 1'b1;
        cycles(1);

        // 100/7 with busy length measured
        start(1, 100, 7, 1);
        nb = 1;
        while (busy && nb < 60) begin
            cycles(1);
            if (busy) nb++;
        end
        check("busy_len", nb, 33);

        op(1, 32'hFFFF_FFF9, 2);
        op(1, 7, 32'hFFFF_FFFE);
        op(0, 32'hFFFF_FFFF, 32'h10);
        op(1, 32'hFFFF_FFFF, 32'h10);
        op(1, 100, 7);
        op(0, 5, 0);
        op(1, 32'h8000_0000, 32'hFFFF_FFFF);
        op(0, 32'h8000_0000, 32'hFFFF_FFFF);

        // Ignored start while busy
        wait_idle();
        start(1, 100, 7, 1);
        cycles(4);
        divInit    = 1'b1;
        value_A_Dd = 9;
        value_B_Ds = 3;
        cycles(1);
        divInit = 1'b0;

        // Back-to-back: starts in the done cycle
        wait_idle();
        check("b2b_done_cycle", done, 1);
        start(1, 20, 3, 1);

        // Reset mid-run
        wait_idle();
        cycles(2);
        start(1, 100, 7, 0);
        cycles(9);
        reset = 1'b0;
        cycles(1);
        reset = 1'b1;
        last_hi = 0;
        last_lo = 0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_low", low, 0);
        cycles(40);

        // Randomised operations
        spec[0] = 32'h8000_0000;
        spec[1] = 32'hFFFF_FFFF;
        spec[2] = 32'h7FFF_FFFF;
        spec[3] = 0;
        spec[4] = 1;
        spec[5] = 32'hFFFF_FFFE;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(0, 20);
                2: rb = spec[$urandom_range(0, 5)];
                default: rb = -$urandom_range(1, 300);
            endcase
            if ($urandom_range(0, 4) == 0) ra = spec[$urandom_range(0, 5)];
            op($urandom_range(0, 1), ra, rb);
        end

        wait_idle();
        cycles(3);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
